// File: rtl/chan_block_arbiter_pkg.sv
// Shared constants for the channel block arbiter: header field positions,
// datapath widths and the one-hot FSM state encoding.
package chan_blk_pkg;

  localparam int unsigned HDR_START_BIT  = 15;
  localparam int unsigned HDR_MASTER_BIT = 14;
  localparam int unsigned HDR_NUM_MSB    = 13;
  localparam int unsigned HDR_NUM_LSB    = 8;
  localparam int unsigned HDR_LEN_MSB    = 7;
  localparam int unsigned HDR_LEN_LSB    = 0;

  localparam int unsigned WORD_W = 16;
  localparam int unsigned REM_W  = 9;
  localparam int unsigned ERR_W  = 16;
  localparam int unsigned CH_W   = 6;

  localparam logic [3:0] ST_IDLE = 4'b0001;
  localparam logic [3:0] ST_HDR  = 4'b0010;
  localparam logic [3:0] ST_TRG  = 4'b0100;
  localparam logic [3:0] ST_DATA = 4'b1000;

  typedef enum logic [3:0] {
    S_IDLE = ST_IDLE,
    S_HDR  = ST_HDR,
    S_TRG  = ST_TRG,
    S_DATA = ST_DATA
  } state_e;

  // Data-word count carried in a block header, widened to the remaining-words counter.
  function automatic logic [REM_W-1:0] hdr_len(input logic [WORD_W-1:0] w);
    return REM_W'(w[HDR_LEN_MSB:HDR_LEN_LSB]);
  endfunction

endpackage

// File: rtl/chan_block_arbiter_if.sv
// Channel-side and merged-stream signals of the block arbiter.
// master = arbiter side, slave = channel array / downstream side.
interface chan_block_arbiter_if
  import chan_blk_pkg::*;
#(
  parameter int unsigned NCH = 16
);
  logic [WORD_W*NCH-1:0] ch_dout;
  logic [NCH-1:0]        ch_req;
  logic [NCH-1:0]        ch_ack;
  logic [WORD_W-1:0]     dout;
  logic                  dvalid;
  logic                  dready;
  logic                  dlast;
  logic [CH_W-1:0]       cur_ch;
  logic                  busy;
  logic [ERR_W-1:0]      err_cnt;

  modport master (
    input  ch_dout, ch_req, dready,
    output ch_ack, dout, dvalid, dlast, cur_ch, busy, err_cnt
  );

  modport slave (
    output ch_dout, ch_req, dready,
    input  ch_ack, dout, dvalid, dlast, cur_ch, busy, err_cnt
  );
endinterface

// File: rtl/chan_block_arbiter_rr_pick.sv
// Round-robin priority encoder: first asserted req at or after ptr, wrapping.
module rr_pick #(
  parameter  int unsigned NCH = 16,
  localparam int unsigned IW  = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic [NCH-1:0] req,
  input  logic [IW-1:0]  ptr,
  output logic [IW-1:0]  idx,
  output logic           any
);
  int k;

  // Scan from the farthest offset down so the nearest request wins last.
  always_comb begin
    idx = '0;
    any = 1'b0;
    k   = 0;
    for (int i = NCH - 1; i >= 0; i--) begin
      k = (int'(ptr) + i) % int'(NCH);
      if (req[IW'(k)]) begin
        idx = IW'(k);
        any = 1'b1;
      end
    end
  end
endmodule

// File: rtl/chan_block_arbiter.sv
// Merges per-channel block FIFOs into one 16-bit stream, one whole block per grant.
// Optional stall watchdog with zero padding: define ARB_TIMEOUT_EN.
module chan_block_arbiter
  import chan_blk_pkg::*;
#(
  parameter int unsigned NCH = 16
`ifdef ARB_TIMEOUT_EN
  , parameter int unsigned TOWIDTH = 8
`endif
) (
  input logic                  clk,
  input logic                  reset,
  chan_block_arbiter_if.master bus
);
  localparam int unsigned IW = (NCH > 1) ? $clog2(NCH) : 1;

  state_e             state_q, state_d;
  logic [IW-1:0]      ch_q, ch_d, rr_q, rr_d;
  logic [REM_W-1:0]   rem_q, rem_d;
  logic [WORD_W-1:0]  dout_q, dout_d;
  logic               dvalid_q, dvalid_d, dlast_q, dlast_d, busy_q, busy_d;
  logic [ERR_W-1:0]   err_q, err_d;

  logic [WORD_W-1:0]  words [NCH];
  logic [NCH-1:0]     ack_c;
  logic [IW-1:0]      pick_idx;
  logic               pick_any;
  logic [WORD_W-1:0]  word;
  logic               vld, fire, emit, last, to_idle, err_inc, pad;

  for (genvar g = 0; g < NCH; g++) begin : g_words
    assign words[g] = bus.ch_dout[WORD_W*g +: WORD_W];
  end

  rr_pick #(.NCH(NCH)) u_pick (
    .req (bus.ch_req),
    .ptr (rr_q),
    .idx (pick_idx),
    .any (pick_any)
  );

`ifdef ARB_TIMEOUT_EN
  localparam int unsigned WD_MAX = (1 << TOWIDTH) - 1;
  logic [TOWIDTH-1:0] wd_q, wd_d;
  logic               pad_q, pad_d;
  assign pad = pad_q;
`else
  assign pad = 1'b0;
`endif

  always_comb begin
    state_d  = state_q;
    ch_d     = ch_q;
    rr_d     = rr_q;
    rem_d    = rem_q;
    dout_d   = dout_q;
    dvalid_d = dvalid_q && !bus.dready;
    dlast_d  = dlast_q && !bus.dready;
    err_d    = err_q;
    ack_c    = '0;
    emit     = 1'b0;
    last     = 1'b0;
    to_idle  = 1'b0;
    err_inc  = 1'b0;
    // While padding, the granted channel is replaced by an always-valid zero source.
    word     = pad ? '0 : words[ch_q];
    vld      = pad || bus.ch_req[ch_q];
    fire     = (state_q != S_IDLE) && vld && (!dvalid_q || bus.dready);
    if (fire && !pad) ack_c = NCH'(1) << ch_q;

    case (state_q)
      S_IDLE: if (pick_any) begin
        ch_d    = pick_idx;
        state_d = S_HDR;
      end
      S_HDR: if (fire) begin
        if (!word[HDR_START_BIT]) begin
          err_inc = 1'b1;
          to_idle = 1'b1;
        end else begin
          emit  = 1'b1;
          rem_d = hdr_len(word);
          if (word[HDR_MASTER_BIT])       state_d = S_TRG;
          else if (hdr_len(word) == '0) begin
            last    = 1'b1;
            to_idle = 1'b1;
          end else                        state_d = S_DATA;
        end
      end
      S_TRG: if (fire) begin
        emit = 1'b1;
        if (rem_q == '0) begin
          last    = 1'b1;
          to_idle = 1'b1;
        end else state_d = S_DATA;
      end
      S_DATA: if (fire) begin
        emit  = 1'b1;
        rem_d = rem_q - 1'b1;
        if (rem_q == REM_W'(1)) begin
          last    = 1'b1;
          to_idle = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase

`ifdef ARB_TIMEOUT_EN
    wd_d  = wd_q;
    pad_d = pad_q;
    // Watchdog: a stalled header just abandons the grant; a stalled body is padded out.
    if (state_q == S_IDLE || (fire && !pad_q)) begin
      wd_d = '0;
    end else if (!pad_q && !bus.ch_req[ch_q]) begin
      if (wd_q == TOWIDTH'(WD_MAX - 1)) begin
        wd_d    = '0;
        err_inc = 1'b1;
        if (state_q == S_HDR) to_idle = 1'b1;
        else                  pad_d   = 1'b1;
      end else begin
        wd_d = wd_q + 1'b1;
      end
    end
    if (to_idle) pad_d = 1'b0;
`endif

    if (emit) begin
      dout_d   = word;
      dvalid_d = 1'b1;
      dlast_d  = last;
    end
    if (to_idle) begin
      state_d = S_IDLE;
      rr_d    = (ch_q == IW'(NCH - 1)) ? '0 : ch_q + 1'b1;
    end
    if (err_inc && err_q != '1) err_d = err_q + 1'b1;
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      ch_q     <= '0;
      rr_q     <= '0;
      rem_q    <= '0;
      dout_q   <= '0;
      dvalid_q <= 1'b0;
      dlast_q  <= 1'b0;
      busy_q   <= 1'b0;
      err_q    <= '0;
`ifdef ARB_TIMEOUT_EN
      wd_q     <= '0;
      pad_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      ch_q     <= ch_d;
      rr_q     <= rr_d;
      rem_q    <= rem_d;
      dout_q   <= dout_d;
      dvalid_q <= dvalid_d;
      dlast_q  <= dlast_d;
      busy_q   <= busy_d;
      err_q    <= err_d;
`ifdef ARB_TIMEOUT_EN
      wd_q     <= wd_d;
      pad_q    <= pad_d;
`endif
    end
  end

  assign bus.ch_ack  = ack_c;
  assign bus.dout    = dout_q;
  assign bus.dvalid  = dvalid_q;
  assign bus.dlast   = dlast_q;
  assign bus.cur_ch  = CH_W'(ch_q);
  assign bus.busy    = busy_q;
  assign bus.err_cnt = err_q;
endmodule

// File: tb/tb_chan_block_arbiter.sv
// Self-checking bench for chan_block_arbiter: queue-based channel sources,
// stream monitor and a block-level round-robin reference model.
module tb_chan_block_arbiter;
  import chan_blk_pkg::*;

  localparam int NCH = 8;
  localparam int CW  = $clog2(NCH);

  logic clk = 1'b0;
  logic reset = 1'b1;

  chan_block_arbiter_if #(.NCH(NCH)) bus ();

`ifdef ARB_TIMEOUT_EN
  chan_block_arbiter #(.NCH(NCH), .TOWIDTH(4)) dut (.clk(clk), .reset(reset), .bus(bus));
`else
  chan_block_arbiter #(.NCH(NCH)) dut (.clk(clk), .reset(reset), .bus(bus));
`endif

  always #4 clk = ~clk;

  typedef struct {
    logic [15:0] w;
    logic        l;
    int          cyc;
  } beat_t;

  int          checks = 0;
  int          errors = 0;
  int          cycle = 0;
  logic [15:0] chq [NCH][$];
  logic [15:0] mq  [NCH][$];
  beat_t       outq[$];
  beat_t       expq[$];
  int          exp_err;
  logic [NCH-1:0] ack_seen = '0;
  bit          rdy_rand = 1'b0;
  bit          stall_en = 1'b0;
  logic        rdy_val = 1'b1;
  bit          held = 1'b0;
  logic [15:0] held_w;
  logic        held_l;

  always @(posedge clk) cycle++;

  // Channel sources: pop the word acked at this edge, then present the next one.
  always @(posedge clk) begin
    logic [16*NCH-1:0] d;
    logic [NCH-1:0]    r;
    logic [15:0]       w;
    logic              q;
    #1;
    for (int k = 0; k < NCH; k++)
      if (ack_seen[k[CW-1:0]] && chq[k].size() > 0) void'(chq[k].pop_front());
    d = '0;
    r = '0;
    for (int k = NCH - 1; k >= 0; k--) begin
      w = 16'($urandom);
      q = 1'b0;
      if (chq[k].size() > 0) begin
        w = chq[k][0];
        q = !(stall_en && bus.busy && int'(bus.cur_ch) == k && $urandom_range(0, 3) == 0);
      end
      d = {d[16*NCH-17:0], w};
      r = {r[NCH-2:0], q};
    end
    bus.ch_dout = d;
    bus.ch_req  = r;
    bus.dready  = rdy_rand ? 1'($urandom_range(0, 1)) : rdy_val;
  end

  // Stream monitor: ack legality, hold-under-backpressure, and capture of accepted beats.
  always @(negedge clk) begin
    ack_seen = bus.ch_ack;
    if (reset) begin
      held = 1'b0;
    end else begin
      if (bus.ch_ack != '0) begin
        checks++;
        if ($countones(bus.ch_ack) != 1 || (bus.ch_ack & ~bus.ch_req) != '0 ||
            (bus.dvalid && !bus.dready)) begin
          errors++;
          $display("FAIL ack_rule: ack=%h req=%h dvalid=%b dready=%b",
                   bus.ch_ack, bus.ch_req, bus.dvalid, bus.dready);
        end
      end
      if (held) begin
        checks++;
        if (bus.dvalid !== 1'b1 || bus.dout !== held_w || bus.dlast !== held_l) begin
          errors++;
          $display("FAIL hold: got dvalid=%b dout=%h dlast=%b, want 1 %h %b",
                   bus.dvalid, bus.dout, bus.dlast, held_w, held_l);
        end
      end
      held   = bus.dvalid && !bus.dready;
      held_w = bus.dout;
      held_l = bus.dlast;
      if (bus.dvalid && bus.dready) outq.push_back('{w: bus.dout, l: bus.dlast, cyc: cycle});
    end
  end

  function automatic logic [15:0] mk_hdr(input int ch, input bit m, input int len);
    logic [15:0] h;
    h = '0;
    h[HDR_START_BIT]             = 1'b1;
    h[HDR_MASTER_BIT]            = m;
    h[HDR_NUM_MSB:HDR_NUM_LSB]   = CH_W'(ch);
    h[HDR_LEN_MSB:HDR_LEN_LSB]   = 8'(len);
    return h;
  endfunction

  task automatic push_block(input int ch, input bit m, input int len);
    chq[ch].push_back(mk_hdr(ch, m, len));
    if (m) chq[ch].push_back(16'($urandom));
    for (int j = 0; j < len; j++) chq[ch].push_back(16'($urandom));
  endtask

  // Reference: whole blocks served in round-robin order over the pending channel queues.
  function automatic void model_build(input int start);
    int          p, c, len;
    logic [15:0] w;
    for (int k = 0; k < NCH; k++) mq[k] = chq[k];
    expq.delete();
    exp_err = 0;
    p = start;
    forever begin
      c = -1;
      for (int i = 0; i < NCH; i++)
        if (c < 0 && mq[(p + i) % NCH].size() > 0) c = (p + i) % NCH;
      if (c < 0) break;
      w = mq[c].pop_front();
      if (!w[HDR_START_BIT]) begin
        exp_err++;
      end else begin
        len = int'(w[HDR_LEN_MSB:HDR_LEN_LSB]);
        expq.push_back('{w: w, l: (len == 0 && !w[HDR_MASTER_BIT]), cyc: 0});
        if (w[HDR_MASTER_BIT] && mq[c].size() > 0)
          expq.push_back('{w: mq[c].pop_front(), l: (len == 0), cyc: 0});
        for (int j = 0; j < len && mq[c].size() > 0; j++)
          expq.push_back('{w: mq[c].pop_front(), l: (j == len - 1), cyc: 0});
      end
      p = (c + 1) % NCH;
    end
  endfunction

  task automatic apply_reset();
    reset = 1'b1;
    for (int k = 0; k < NCH; k++) chq[k].delete();
    rdy_rand = 1'b0;
    rdy_val  = 1'b1;
    stall_en = 1'b0;
    repeat (2) @(negedge clk);
    ack_seen = '0;
    outq.delete();
    reset = 1'b0;
  endtask

  task automatic wait_done(input int budget, output bit ok);
    bit empty;
    ok = 1'b0;
    for (int n = 0; n < budget; n++) begin
      @(negedge clk);
      #1;
      empty = 1'b1;
      for (int k = 0; k < NCH; k++) if (chq[k].size() != 0) empty = 1'b0;
      if (empty && outq.size() >= expq.size() && !bus.busy && !bus.dvalid) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    checks += 7;
    if (bus.ch_ack  !== '0)    begin errors++; $display("FAIL rst_ack: got %h want 0", bus.ch_ack); end
    if (bus.dout    !== 16'h0) begin errors++; $display("FAIL rst_dout: got %h want 0", bus.dout); end
    if (bus.dvalid  !== 1'b0)  begin errors++; $display("FAIL rst_dvalid: got %b want 0", bus.dvalid); end
    if (bus.dlast   !== 1'b0)  begin errors++; $display("FAIL rst_dlast: got %b want 0", bus.dlast); end
    if (bus.cur_ch  !== 6'd0)  begin errors++; $display("FAIL rst_cur_ch: got %0d want 0", bus.cur_ch); end
    if (bus.busy    !== 1'b0)  begin errors++; $display("FAIL rst_busy: got %b want 0", bus.busy); end
    if (bus.err_cnt !== 16'h0) begin errors++; $display("FAIL rst_err: got %0d want 0", bus.err_cnt); end
  endtask

  task automatic test_self_block();
    bit ok;
    bit seen;
    apply_reset();
    chq[3].push_back(16'h8303);
    for (int j = 0; j < 3; j++) chq[3].push_back(16'($urandom));
    model_build(0);
    seen = 1'b0;
    for (int n = 0; n < 20 && !seen; n++) begin
      @(negedge clk);
      #1;
      seen = (bus.ch_ack != '0);
    end
    checks++;
    if (bus.ch_ack !== 8'b0000_1000) begin
      errors++; $display("FAIL self_first_ack: got %b want 00001000", bus.ch_ack);
    end
    @(negedge clk);
    #1;
    checks++;
    if (bus.dvalid !== 1'b1 || bus.dout !== 16'h8303) begin
      errors++; $display("FAIL self_latency: got dvalid=%b dout=%h want 1 8303", bus.dvalid, bus.dout);
    end
    wait_done(200, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL self_timeout: got no drain want drain"); end
    checks++;
    if (outq.size() != 4) begin errors++; $display("FAIL self_count: got %0d want 4", outq.size()); end
    for (int i = 0; i < expq.size() && i < outq.size(); i++) begin
      checks++;
      if (outq[i].w !== expq[i].w || outq[i].l !== expq[i].l) begin
        errors++;
        $display("FAIL self_word%0d: got %h/%b want %h/%b", i, outq[i].w, outq[i].l, expq[i].w, expq[i].l);
      end
    end
  endtask

  task automatic test_master_block();
    bit ok;
    apply_reset();
    chq[0].push_back(16'hC002);
    chq[0].push_back(16'h8ABC);
    chq[0].push_back(16'h1234);
    chq[0].push_back(16'h5678);
    chq[0].push_back(16'hC000);
    chq[0].push_back(16'h8DEF);
    model_build(0);
    wait_done(300, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL master_timeout: got no drain want drain"); end
    checks++;
    if (outq.size() != expq.size()) begin
      errors++; $display("FAIL master_count: got %0d want %0d", outq.size(), expq.size());
    end
    for (int i = 0; i < expq.size() && i < outq.size(); i++) begin
      checks++;
      if (outq[i].w !== expq[i].w || outq[i].l !== expq[i].l) begin
        errors++;
        $display("FAIL master_word%0d: got %h/%b want %h/%b", i, outq[i].w, outq[i].l, expq[i].w, expq[i].l);
      end
    end
  endtask

  task automatic test_rr_order();
    bit ok;
    apply_reset();
    push_block(1, 1'b0, 2);
    push_block(2, 1'b0, 1);
    push_block(5, 1'b1, 3);
    push_block(1, 1'b0, 1);
    model_build(0);
    wait_done(400, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL rr_timeout: got no drain want drain"); end
    checks++;
    if (outq.size() != expq.size()) begin
      errors++; $display("FAIL rr_count: got %0d want %0d", outq.size(), expq.size());
    end
    for (int i = 0; i < expq.size() && i < outq.size(); i++) begin
      checks++;
      if (outq[i].w !== expq[i].w || outq[i].l !== expq[i].l) begin
        errors++;
        $display("FAIL rr_word%0d: got %h/%b want %h/%b", i, outq[i].w, outq[i].l, expq[i].w, expq[i].l);
      end
    end
  endtask

  task automatic test_backpressure();
    bit          ok;
    logic [15:0] w0;
    apply_reset();
    push_block(4, 1'b0, 6);
    model_build(0);
    for (int n = 0; n < 50 && outq.size() < 2; n++) @(negedge clk);
    rdy_val = 1'b0;
    @(negedge clk);
    #1;
    w0 = bus.dout;
    checks++;
    if (bus.dvalid !== 1'b1) begin errors++; $display("FAIL bp_valid: got %b want 1", bus.dvalid); end
    for (int n = 0; n < 3; n++) begin
      checks++;
      if (bus.dout !== w0 || bus.ch_ack !== '0) begin
        errors++; $display("FAIL bp_stall%0d: got dout=%h ack=%h want %h 0", n, bus.dout, bus.ch_ack, w0);
      end
      if (n < 2) begin
        @(negedge clk);
        #1;
      end
    end
    rdy_val = 1'b1;
    wait_done(300, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL bp_timeout: got no drain want drain"); end
    checks++;
    if (outq.size() != expq.size()) begin
      errors++; $display("FAIL bp_count: got %0d want %0d", outq.size(), expq.size());
    end
    for (int i = 0; i < expq.size() && i < outq.size(); i++) begin
      checks++;
      if (outq[i].w !== expq[i].w || outq[i].l !== expq[i].l) begin
        errors++;
        $display("FAIL bp_word%0d: got %h/%b want %h/%b", i, outq[i].w, outq[i].l, expq[i].w, expq[i].l);
      end
    end
  endtask

  task automatic test_bad_header();
    bit ok;
    apply_reset();
    chq[4].push_back(16'h0123);
    push_block(4, 1'b0, 2);
    model_build(0);
    wait_done(300, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL badhdr_timeout: got no drain want drain"); end
    checks++;
    if (outq.size() != 3) begin errors++; $display("FAIL badhdr_count: got %0d want 3", outq.size()); end
    for (int i = 0; i < expq.size() && i < outq.size(); i++) begin
      checks++;
      if (outq[i].w !== expq[i].w || outq[i].l !== expq[i].l) begin
        errors++;
        $display("FAIL badhdr_word%0d: got %h/%b want %h/%b", i, outq[i].w, outq[i].l, expq[i].w, expq[i].l);
      end
    end
    checks++;
    if (bus.err_cnt !== 16'(exp_err) || exp_err != 1) begin
      errors++; $display("FAIL badhdr_err: got %0d want 1", bus.err_cnt);
    end
  endtask

  task automatic test_random();
    bit ok;
    apply_reset();
    rdy_rand = 1'b1;
    stall_en = 1'b1;
    for (int b = 0; b < 14; b++)
      push_block($urandom_range(0, NCH - 1), 1'($urandom_range(0, 1)), $urandom_range(0, 6));
    model_build(0);
    wait_done(4000, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL rand_timeout: got no drain want drain"); end
    checks++;
    if (outq.size() != expq.size()) begin
      errors++; $display("FAIL rand_count: got %0d want %0d", outq.size(), expq.size());
    end
    for (int i = 0; i < expq.size() && i < outq.size(); i++) begin
      checks++;
      if (outq[i].w !== expq[i].w || outq[i].l !== expq[i].l) begin
        errors++;
        $display("FAIL rand_word%0d: got %h/%b want %h/%b", i, outq[i].w, outq[i].l, expq[i].w, expq[i].l);
      end
    end
    checks++;
    if (bus.err_cnt !== 16'(exp_err)) begin
      errors++; $display("FAIL rand_err: got %0d want %0d", bus.err_cnt, exp_err);
    end
  endtask

  task automatic test_reset_mid_block();
    int n0;
    apply_reset();
    push_block(2, 1'b0, 20);
    for (int n = 0; n < 50 && outq.size() < 3; n++) @(negedge clk);
    reset = 1'b1;
    #1;
    checks++;
    if (bus.busy !== 1'b0 || bus.dvalid !== 1'b0 || bus.dlast !== 1'b0 || bus.ch_ack !== '0) begin
      errors++;
      $display("FAIL midrst_clear: got busy=%b dvalid=%b dlast=%b ack=%h want 0 0 0 0",
               bus.busy, bus.dvalid, bus.dlast, bus.ch_ack);
    end
    for (int k = 0; k < NCH; k++) chq[k].delete();
    @(negedge clk);
    n0 = outq.size();
    reset = 1'b0;
    repeat (6) @(negedge clk);
    #1;
    checks++;
    if (outq.size() != n0 || bus.busy !== 1'b0) begin
      errors++; $display("FAIL midrst_quiet: got %0d new beats busy=%b want 0 0", outq.size() - n0, bus.busy);
    end
  endtask

`ifdef ARB_TIMEOUT_EN
  task automatic test_timeout();
    bit ok;
    apply_reset();
    chq[6].push_back(mk_hdr(6, 1'b0, 5));
    chq[6].push_back(16'h1111);
    expq.delete();
    expq.push_back('{w: mk_hdr(6, 1'b0, 5), l: 1'b0, cyc: 0});
    expq.push_back('{w: 16'h1111, l: 1'b0, cyc: 0});
    for (int j = 0; j < 4; j++) expq.push_back('{w: 16'h0000, l: (j == 3), cyc: 0});
    wait_done(200, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL wd_timeout: got no drain want drain"); end
    checks++;
    if (outq.size() != 6) begin errors++; $display("FAIL wd_count: got %0d want 6", outq.size()); end
    for (int i = 0; i < expq.size() && i < outq.size(); i++) begin
      checks++;
      if (outq[i].w !== expq[i].w || outq[i].l !== expq[i].l) begin
        errors++;
        $display("FAIL wd_word%0d: got %h/%b want %h/%b", i, outq[i].w, outq[i].l, expq[i].w, expq[i].l);
      end
    end
    if (outq.size() >= 3) begin
      checks++;
      if (outq[2].cyc - outq[1].cyc != 16) begin
        errors++; $display("FAIL wd_gap: got %0d want 16", outq[2].cyc - outq[1].cyc);
      end
    end
    checks++;
    if (bus.err_cnt !== 16'd1) begin errors++; $display("FAIL wd_err: got %0d want 1", bus.err_cnt); end
  endtask
`endif

  initial begin
    test_reset();
    test_self_block();
    test_master_block();
    test_rr_order();
    test_backpressure();
    test_bad_header();
    test_random();
    test_reset_mid_block();
`ifdef ARB_TIMEOUT_EN
    test_timeout();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
